aes_sub_bytes: RTL and testbench

- AES SubBytes stage of the encryption round datapath.
- Applies the FIPS-197 forward S-box to each of the 16 bytes of a 128-bit state independently.
- Sits between AddRoundKey and ShiftRows.
- Default build is purely combinational. An optional build adds a one-cycle output register.

---
 rtl/aes_sub_bytes.sv | 67 ++++++
 tb/tb_aes_sub_bytes.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/aes_sub_bytes.sv
// aes_sub_bytes: AES forward S-box applied independently to all 16 byte lanes
// of a 128-bit state. Lane k occupies bits [8k+7:8k]. Lane order is preserved.
// The default build is purely combinational.
// Define SUB_BYTES_REG_OUT_EN to register the output. This gives 1-cycle latency
// and a synchronous active-high reset that clears the output to zero.
module aes_sub_bytes (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [127:0] i_initial_state,
  output logic [127:0] o_result_state
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] v);
    return SBOX[v];
  endfunction

  logic [127:0] w_sub;

  // Substitute every byte lane in place
  always_comb begin
    w_sub = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      w_sub[8*k +: 8] = sbox(i_initial_state[8*k +: 8]);
    end
  end

`ifdef SUB_BYTES_REG_OUT_EN
  logic [127:0] r_result;

  // Output register; reset wins over new data
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_result <= '0;
    end else begin
      r_result <= w_sub;
    end
  end

  assign o_result_state = r_result;
`else
  // Clock and reset have no function in the combinational build
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = i_clk ^ i_rst;

  assign o_result_state = w_sub;
`endif

endmodule

// File: tb/tb_aes_sub_bytes.sv
// tb_aes_sub_bytes: bench for aes_sub_bytes. The reference S-box is derived
// arithmetically as the GF(2^8) inverse followed by the affine map. It covers
// both the default and the SUB_BYTES_REG_OUT_EN build.
module tb_aes_sub_bytes;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] din = '0;
  logic [127:0] dout;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  logic [7:0] ref_tab [256];
  logic [127:0] exp_q;

  aes_sub_bytes dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_initial_state(din),
    .o_result_state(dout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] calc_sbox(input logic [7:0] v);
    logic [7:0] inv = 8'h00;
    logic [7:0] c = 8'h63;
    logic [7:0] r;
    for (int b = 1; b < 256; b++) begin
      if (gmul(v, 8'(b)) == 8'h01) inv = 8'(b);
    end
    for (int i = 0; i < 8; i++) begin
      r[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    end
    return r;
  endfunction

  function automatic logic [127:0] model_state(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_tab[s[8*k +: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference for the registered build: value captured at each rising edge
  always @(posedge clk) exp_q <= rst ? 128'h0 : model_state(din);

  // Single compare process, sampled away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
`ifdef SUB_BYTES_REG_OUT_EN
      check("stream", dout, exp_q);
`else
      check("stream", dout, model_state(din));
`endif
    end
  end

  logic [127:0] vin [6];
  logic [127:0] vout [6];

  initial begin
    vin[0] = 128'h00102030405060708090a0b0c0d0e0f0; vout[0] = 128'h63cab7040953d051cd60e0e7ba70e18c;
    vin[1] = 128'h89d810e8855ace682d1843d8cb128fe4; vout[1] = 128'ha761ca9b97be8b45d8ad1a611fc97369;
    vin[2] = 128'hc81677bc9b7ac93b25027992b0261996; vout[2] = 128'he847f56514dadde23f77b64fe7f7d490;
    vin[3] = 128'h4915598f55e5d7a0daca94fa1f0a63f7; vout[3] = 128'h3b59cb73fcd90ee05774222dc067fb68;
    vin[4] = 128'hfa636a2825b339c940668a3157244d17; vout[4] = 128'h2dfb02343f6d12dd09337ec75b36e3f0;
    vin[5] = 128'h247240236966b3fa6ed2753288425b6c; vout[5] = 128'h36400926f9336d2d9fb59d23c42c3950;

    for (int v = 0; v < 256; v++) ref_tab[v] = calc_sbox(8'(v));

    // Pin the reference model itself against known S-box values
    check("model_00", {120'h0, ref_tab[8'h00]}, 128'h63);
    check("model_01", {120'h0, ref_tab[8'h01]}, 128'h7c);
    check("model_10", {120'h0, ref_tab[8'h10]}, 128'hca);
    check("model_53", {120'h0, ref_tab[8'h53]}, 128'hed);
    check("model_80", {120'h0, ref_tab[8'h80]}, 128'hcd);
    check("model_ff", {120'h0, ref_tab[8'hff]}, 128'h16);
    for (int i = 0; i < 6; i++) check("model_vec", model_state(vin[i]), vout[i]);

`ifdef SUB_BYTES_REG_OUT_EN
    rst = 1'b1;
    din = vin[3];
    @(posedge clk); @(posedge clk); #1;
    check("reset_hold", dout, 128'h0);
    rst = 1'b0;
    din = vin[0];
    #1 check("pre_edge_zero", dout, 128'h0);
    @(posedge clk); #1;
    check("vec0_lat1", dout, vout[0]);
    din = vin[1];
    @(posedge clk); #1;
    check("vec1", dout, vout[1]);
    din = vin[2];
    @(posedge clk); #1;
    check("vec2", dout, vout[2]);
    din = vin[3];
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_midstream", dout, 128'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("vec3_after_rst", dout, vout[3]);
`else
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      din = vin[i];
      #1 check("literal_vec", dout, vout[i]);
    end
`endif

    chk_en = 1'b1;
    // Exhaustive sweep: all 16 lanes carry the same byte
    for (int v = 0; v < 256; v++) begin
      @(posedge clk); #1;
      din = {16{8'(v)}};
    end
    // Random states with occasional reset pulses
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      din = {$urandom, $urandom, $urandom, $urandom};
      rst = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_en = 1'b0;
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
